// File: rtl/dump_pkg.sv
// Shared types and constants for the ROM-to-UART dump engine.
// State encoding, sync byte and busy-rise timeout.
package dump_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HDR     = 4'd1;
  localparam logic [3:0] ST_FETCH   = 4'd2;
  localparam logic [3:0] ST_LOAD    = 4'd3;
  localparam logic [3:0] ST_SEND    = 4'd4;
  localparam logic [3:0] ST_WAIT_HI = 4'd5;
  localparam logic [3:0] ST_WAIT_LO = 4'd6;
  localparam logic [3:0] ST_CSUM    = 4'd7;
  localparam logic [3:0] ST_FIN     = 4'd8;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    HDR     = ST_HDR,
    FETCH   = ST_FETCH,
    LOAD    = ST_LOAD,
    SEND    = ST_SEND,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO,
    CSUM    = ST_CSUM,
    FIN     = ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_PAY,
    PH_CSUM
  } phase_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int WAIT_HI_TIMEOUT = 4;

  function automatic logic [7:0] hdr_byte(
    input logic [1:0]  idx,
    input logic [15:0] len
  );
    case (idx)
      2'd0:    hdr_byte = SYNC_BYTE;
      2'd1:    hdr_byte = len[15:8];
      default: hdr_byte = len[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rom_uart_dumper_if.sv
// ROM read port and uart_send byte port of the dump engine.
// master = dump engine, slave = ROM / uart_send side.
interface rom_uart_dumper_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;
  logic              uart_en;
  logic [7:0]        uart_din;
  logic              uart_busy;

  modport master (
    output rom_addr, uart_en, uart_din,
    input  rom_rdata, uart_busy
  );

  modport slave (
    input  rom_addr, uart_en, uart_din,
    output rom_rdata, uart_busy
  );
endinterface

// File: rtl/rom_read_pipe.sv
// Marks the cycle in which rom_rdata belongs to the last issued address.
// One flop per cycle of ROM latency.
module rom_read_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic issue,
  output logic valid
);

  logic [LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = LAT'({sr_q, issue});
    if (flush) sr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign valid = sr_q[LAT-1];

endmodule

// File: rtl/rom_uart_dumper.sv
// Streams a ROM window to uart_send, MSB byte first,
// with optional A5/length header and trailing checksum.
import dump_pkg::*;

module rom_uart_dumper #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int ROM_LAT   = 1,
  parameter int HEADER_EN = 1,
  parameter int CSUM_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  rom_uart_dumper_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        csum
);

  localparam int BYTES = DATA_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [BI_W-1:0]   bidx_q, bidx_d;
  logic [1:0]        hidx_q, hidx_d;
  logic [2:0]        tmo_q, tmo_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [7:0]        csum_q, csum_d;
  logic              en_q, en_d;
  logic [7:0]        din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              issue_q, issue_d;

  logic              rd_valid;
  logic [15:0]       len;
  logic [ADDR_W:0]   widx_nxt;
  logic [DATA_W-1:0] sh_nxt;

  rom_read_pipe #(.LAT(ROM_LAT)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .issue (issue_q),
    .valid (rd_valid)
  );

  assign len      = 16'(32'(words_q) * BYTES);
  assign widx_nxt = widx_q + (ADDR_W+1)'(1);
  assign sh_nxt   = shreg_q << 8;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    base_d  = base_q;
    words_d = words_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    hidx_d  = hidx_q;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    csum_d  = csum_q;
    en_d    = 1'b0;
    din_d   = din_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          base_d  = base_addr;
          words_d = num_words;
          widx_d  = '0;
          bidx_d  = '0;
          hidx_d  = '0;
          csum_d  = '0;
          busy_d  = 1'b1;
          if (HEADER_EN != 0) begin
            state_d = HDR;
            phase_d = PH_HDR;
          end else if (num_words == '0) begin
            if (CSUM_EN != 0) state_d = CSUM;
            else              state_d = FIN;
          end else begin
            state_d = FETCH;
            phase_d = PH_PAY;
            addr_d  = base_addr;
            issue_d = 1'b1;
          end
        end
        HDR: if (!bus.uart_busy) begin
          state_d = SEND;
          en_d    = 1'b1;
          din_d   = hdr_byte(hidx_q, len);
        end
        FETCH: if (rd_valid) begin
          shreg_d = bus.rom_rdata;
          state_d = LOAD;
        end
        LOAD: if (!bus.uart_busy) begin
          state_d = SEND;
          en_d    = 1'b1;
          din_d   = shreg_q[DATA_W-1 -: 8];
          csum_d  = csum_q + shreg_q[DATA_W-1 -: 8];
        end
        SEND: begin
          state_d = WAIT_HI;
          tmo_d   = '0;
        end
        // A transmitter that never raises busy must not stall the dump
        WAIT_HI: begin
          if (bus.uart_busy || tmo_q == 3'(WAIT_HI_TIMEOUT - 1))
            state_d = WAIT_LO;
          else
            tmo_d = tmo_q + 3'd1;
        end
        WAIT_LO: if (!bus.uart_busy) begin
          unique case (phase_q)
            PH_HDR: begin
              if (hidx_q != 2'd2) begin
                hidx_d  = hidx_q + 2'd1;
                state_d = HDR;
              end else if (words_q == '0) begin
                if (CSUM_EN != 0) state_d = CSUM;
                else              state_d = FIN;
              end else begin
                phase_d = PH_PAY;
                state_d = FETCH;
                addr_d  = base_q;
                issue_d = 1'b1;
              end
            end
            PH_PAY: begin
              if (bidx_q != BI_W'(BYTES - 1)) begin
                bidx_d  = bidx_q + BI_W'(1);
                shreg_d = sh_nxt;
                state_d = SEND;
                en_d    = 1'b1;
                din_d   = sh_nxt[DATA_W-1 -: 8];
                csum_d  = csum_q + sh_nxt[DATA_W-1 -: 8];
              end else if (widx_nxt == words_q) begin
                if (CSUM_EN != 0) state_d = CSUM;
                else              state_d = FIN;
              end else begin
                widx_d  = widx_nxt;
                bidx_d  = '0;
                state_d = FETCH;
                addr_d  = base_q + widx_nxt[ADDR_W-1:0];
                issue_d = 1'b1;
              end
            end
            default: state_d = FIN;
          endcase
        end
        CSUM: if (!bus.uart_busy) begin
          phase_d = PH_CSUM;
          state_d = SEND;
          en_d    = 1'b1;
          din_d   = csum_q;
        end
        FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_HDR;
      base_q  <= '0;
      words_q <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      hidx_q  <= '0;
      tmo_q   <= '0;
      shreg_q <= '0;
      csum_q  <= '0;
      en_q    <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      base_q  <= base_d;
      words_q <= words_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      hidx_q  <= hidx_d;
      tmo_q   <= tmo_d;
      shreg_q <= shreg_d;
      csum_q  <= csum_d;
      en_q    <= en_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      issue_q <= issue_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.uart_en  = en_q;
  assign bus.uart_din = din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign csum         = csum_q;

endmodule

// File: tb/tb_rom_uart_dumper.sv
// Bench for rom_uart_dumper: two configurations, ROM and uart_send
// models, byte scoreboard checked on every uart_en.
module tb_rom_uart_dumper;

  localparam int BUSY_A = 4;
  localparam int BUSY_B = 20;

  logic clk;
  logic rst_n;

  logic       start_a, abort_a, busy_a, done_a;
  logic [3:0] base_a;
  logic [4:0] num_a;
  logic [7:0] csum_a;

  logic        start_b, abort_b, busy_b, done_b;
  logic [9:0]  base_b;
  logic [10:0] num_b;
  logic [7:0]  csum_b;

  rom_uart_dumper_if #(.ADDR_W(4),  .DATA_W(8))  bus_a ();
  rom_uart_dumper_if #(.ADDR_W(10), .DATA_W(16)) bus_b ();

  rom_uart_dumper #(
    .ADDR_W(4), .DATA_W(8), .ROM_LAT(1), .HEADER_EN(1), .CSUM_EN(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .base_addr(base_a), .num_words(num_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .csum(csum_a)
  );

  rom_uart_dumper #(
    .ADDR_W(10), .DATA_W(16), .ROM_LAT(3), .HEADER_EN(1), .CSUM_EN(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .base_addr(base_b), .num_words(num_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .csum(csum_b)
  );

  int n_run, n_fail;
  int rom_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models
  function automatic logic [7:0] rom_a(input int a);
    if (rom_mode != 0) return 8'(a * 17);
    return 8'(a);
  endfunction

  function automatic logic [15:0] rom_b(input int a);
    if (a == 5) return 16'h1234;
    if (a == 6) return 16'hABCD;
    return {8'(a), ~8'(a)};
  endfunction

  logic [7:0]  rpipe_a;
  logic [15:0] rpipe_b [3];

  always @(posedge clk) begin
    rpipe_a    <= rom_a(int'(bus_a.rom_addr));
    rpipe_b[0] <= rom_b(int'(bus_b.rom_addr));
    rpipe_b[1] <= rpipe_b[0];
    rpipe_b[2] <= rpipe_b[1];
  end

  assign bus_a.rom_rdata = rpipe_a;
  assign bus_b.rom_rdata = rpipe_b[2];

  // uart_send models and scoreboards
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] held_a, held_b, e_a, e_b;
  logic [7:0] exp_csum_a, exp_csum_b;
  int bcnt_a, bcnt_b, en_cnt_a, en_cnt_b, done_cnt_a, done_cnt_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt_a = 0;
      bus_a.uart_busy = 1'b0;
    end else begin
      if (bcnt_a > 0) begin
        bcnt_a--;
        n_run++;
        if (bus_a.uart_din !== held_a) begin
          n_fail++;
          $display("FAIL a_din_stable got %02h want %02h", bus_a.uart_din, held_a);
        end
      end
      if (bus_a.uart_en) begin
        n_run++;
        if (bcnt_a > 0) begin
          n_fail++;
          $display("FAIL a_en_overlap got uart_en=1 want 0 while busy");
        end
        n_run++;
        if (exp_q_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_byte got %02h want none", bus_a.uart_din);
        end else begin
          e_a = exp_q_a.pop_front();
          if (bus_a.uart_din !== e_a) begin
            n_fail++;
            $display("FAIL a_byte got %02h want %02h", bus_a.uart_din, e_a);
          end
        end
        held_a = bus_a.uart_din;
        bcnt_a = BUSY_A;
        en_cnt_a++;
      end
      bus_a.uart_busy = (bcnt_a > 0);
      if (done_a) done_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt_b = 0;
      bus_b.uart_busy = 1'b0;
    end else begin
      if (bcnt_b > 0) begin
        bcnt_b--;
        n_run++;
        if (bus_b.uart_din !== held_b) begin
          n_fail++;
          $display("FAIL b_din_stable got %02h want %02h", bus_b.uart_din, held_b);
        end
      end
      if (bus_b.uart_en) begin
        n_run++;
        if (bcnt_b > 0) begin
          n_fail++;
          $display("FAIL b_en_overlap got uart_en=1 want 0 while busy");
        end
        n_run++;
        if (exp_q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_byte got %02h want none", bus_b.uart_din);
        end else begin
          e_b = exp_q_b.pop_front();
          if (bus_b.uart_din !== e_b) begin
            n_fail++;
            $display("FAIL b_byte got %02h want %02h", bus_b.uart_din, e_b);
          end
        end
        held_b = bus_b.uart_din;
        bcnt_b = BUSY_B;
        en_cnt_b++;
      end
      bus_b.uart_busy = (bcnt_b > 0);
      if (done_b) done_cnt_b++;
    end
  end

  // Expected frame builders
  task automatic plan_a(input int base, input int num);
    logic [7:0] b, s;
    s = 8'h00;
    exp_q_a.push_back(8'hA5);
    exp_q_a.push_back(8'(num >> 8));
    exp_q_a.push_back(8'(num));
    for (int w = 0; w < num; w++) begin
      b = rom_a((base + w) % 16);
      exp_q_a.push_back(b);
      s = s + b;
    end
    exp_q_a.push_back(s);
    exp_csum_a = s;
  endtask

  task automatic plan_b(input int base, input int num);
    logic [15:0] d;
    logic [7:0]  s;
    s = 8'h00;
    exp_q_b.push_back(8'hA5);
    exp_q_b.push_back(8'((num * 2) >> 8));
    exp_q_b.push_back(8'(num * 2));
    for (int w = 0; w < num; w++) begin
      d = rom_b((base + w) % 1024);
      exp_q_b.push_back(d[15:8]);
      exp_q_b.push_back(d[7:0]);
      s = s + d[15:8] + d[7:0];
    end
    exp_q_b.push_back(s);
    exp_csum_b = s;
  endtask

  task automatic pulse_start_a(input int base, input int num);
    @(negedge clk);
    start_a = 1'b1;
    base_a  = 4'(base);
    num_a   = 5'(num);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int d0, input int lim, output bit ok);
    int c = 0;
    while (done_cnt_a == d0 && c < lim) begin
      @(negedge clk);
      c++;
    end
    ok = (done_cnt_a != d0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; base_a = '0; num_a = '0;
    start_b = 1'b0; abort_b = 1'b0; base_b = '0; num_b = '0;
    rom_mode = 0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({bus_a.rom_addr, bus_a.uart_en, bus_a.uart_din, busy_a, done_a, csum_a} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_a got addr=%h en=%b din=%h busy=%b done=%b csum=%h want all 0",
               bus_a.rom_addr, bus_a.uart_en, bus_a.uart_din, busy_a, done_a, csum_a);
    end
    n_run++;
    if ({bus_b.rom_addr, bus_b.uart_en, bus_b.uart_din, busy_b, done_b, csum_b} !== 29'h0) begin
      n_fail++;
      $display("FAIL reset_b got addr=%h en=%b din=%h busy=%b done=%b csum=%h want all 0",
               bus_b.rom_addr, bus_b.uart_en, bus_b.uart_din, busy_b, done_b, csum_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dump_a(input string nm, input int mode, input int base, input int num);
    int d0;
    bit ok;
    rom_mode = mode;
    plan_a(base, num);
    d0 = done_cnt_a;
    pulse_start_a(base, num);
    wait_done_a(d0, 600, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_done got timeout want done pulse", nm);
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (done_cnt_a != d0 + 1) begin
      n_fail++;
      $display("FAIL %s_done_pulses got %0d want 1", nm, done_cnt_a - d0);
    end
    n_run++;
    if (csum_a !== exp_csum_a) begin
      n_fail++;
      $display("FAIL %s_csum got %02h want %02h", nm, csum_a, exp_csum_a);
    end
    n_run++;
    if (exp_q_a.size() != 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end got left=%0d busy=%b want 0 0", nm, exp_q_a.size(), busy_a);
    end
  endtask

  task automatic test_abort;
    int e0, d0, c;
    rom_mode = 0;
    exp_q_a.push_back(8'hA5);
    exp_q_a.push_back(8'h00);
    exp_q_a.push_back(8'h04);
    exp_q_a.push_back(8'h00);
    exp_q_a.push_back(8'h01);
    exp_q_a.push_back(8'h02);
    e0 = en_cnt_a;
    d0 = done_cnt_a;
    pulse_start_a(0, 4);
    c = 0;
    while (en_cnt_a < e0 + 6 && c < 400) begin
      @(negedge clk);
      c++;
    end
    n_run++;
    if (en_cnt_a < e0 + 6) begin
      n_fail++;
      $display("FAIL abort_reach got %0d bytes want 6", en_cnt_a - e0);
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    n_run++;
    if ({busy_a, bus_a.uart_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_next got busy=%b en=%b want 0 0", busy_a, bus_a.uart_en);
    end
    repeat (40) @(negedge clk);
    n_run++;
    if (done_cnt_a != d0 || en_cnt_a != e0 + 6) begin
      n_fail++;
      $display("FAIL abort_quiet got done=%0d bytes=%0d want 0 6",
               done_cnt_a - d0, en_cnt_a - e0);
    end
    test_dump_a("after_abort", 0, 1, 2);
  endtask

  task automatic test_zero_len;
    int d0;
    bit ok;
    rom_mode = 0;
    plan_a(0, 0);
    d0 = done_cnt_a;
    pulse_start_a(0, 0);
    repeat (2) @(negedge clk);
    pulse_start_a(3, 5);
    wait_done_a(d0, 300, ok);
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL zero_done got timeout want done pulse");
    end
    repeat (40) @(negedge clk);
    n_run++;
    if (done_cnt_a != d0 + 1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_end got done=%0d busy=%b want 1 0", done_cnt_a - d0, busy_a);
    end
    n_run++;
    if (csum_a !== 8'h00 || exp_q_a.size() != 0) begin
      n_fail++;
      $display("FAIL zero_csum got csum=%02h left=%0d want 00 0", csum_a, exp_q_a.size());
    end
  endtask

  task automatic test_dump_b(input string nm, input int base, input int num);
    int d0, c;
    plan_b(base, num);
    d0 = done_cnt_b;
    @(negedge clk);
    start_b = 1'b1;
    base_b  = 10'(base);
    num_b   = 11'(num);
    @(negedge clk);
    start_b = 1'b0;
    c = 0;
    while (done_cnt_b == d0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    n_run++;
    if (done_cnt_b == d0) begin
      n_fail++;
      $display("FAIL %s_done got timeout want done pulse", nm);
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (done_cnt_b != d0 + 1) begin
      n_fail++;
      $display("FAIL %s_done_pulses got %0d want 1", nm, done_cnt_b - d0);
    end
    n_run++;
    if (csum_b !== exp_csum_b) begin
      n_fail++;
      $display("FAIL %s_csum got %02h want %02h", nm, csum_b, exp_csum_b);
    end
    n_run++;
    if (exp_q_b.size() != 0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end got left=%0d busy=%b want 0 0", nm, exp_q_b.size(), busy_b);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_dump_a("basic", 0, 0, 4);
    test_dump_a("wrap", 1, 14, 4);
    test_abort();
    test_zero_len();
    test_dump_b("wide", 5, 2);
    test_dump_b("wide_wrap", 1022, 3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
